// File: rtl/neuron_pkg.sv
// Shared types and constants for the neuron scheduler slice.
// Q16.16 fixed point: 1.0 = 32'h0001_0000.
package neuron_pkg;

    localparam int WIDTH_DEF         = 32;
    localparam int REFRACT_STEPS_DEF = 4;

    // Fixed-point unit and the per-neuron start-up values (-65 and -13)
    localparam logic signed [31:0] ONE     = 32'sh0001_0000;
    localparam logic signed [31:0] V_RESET = 32'shffbf_0000;
    localparam logic signed [31:0] W_INIT  = 32'shfff3_0000;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EVAL,
        SPIKE,
        DONE
    } sched_state_t;

endpackage

// File: rtl/neuron_state_ram.sv
// Per-neuron {v, w} storage: N_NEURONS words of 2*WIDTH bits.
// Asynchronous read port, synchronous write port, and a one-cycle bulk
// re-initialisation to the start-up values. Reset also restores them.
module neuron_state_ram
    import neuron_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int N_NEURONS = 8,
    parameter int IDX_W     = 3
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    init,
    input  logic [IDX_W-1:0]        raddr,
    output logic signed [WIDTH-1:0] rdata_v,
    output logic signed [WIDTH-1:0] rdata_w,
    input  logic                    we,
    input  logic [IDX_W-1:0]        waddr,
    input  logic signed [WIDTH-1:0] wdata_v,
    input  logic signed [WIDTH-1:0] wdata_w
);

    localparam logic [2*WIDTH-1:0] INIT_WORD = {WIDTH'(V_RESET), WIDTH'(W_INIT)};

    logic [2*WIDTH-1:0] mem [N_NEURONS];

    // State words: reset/init restore start-up values, otherwise write-back
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_NEURONS; i++) mem[i] <= INIT_WORD;
        end else if (init) begin
            for (int i = 0; i < N_NEURONS; i++) mem[i] <= INIT_WORD;
        end else if (we) begin
            mem[waddr] <= {wdata_v, wdata_w};
        end
    end

    assign rdata_v = mem[raddr][2*WIDTH-1:WIDTH];
    assign rdata_w = mem[raddr][WIDTH-1:0];

endmodule

// File: rtl/neuron_scheduler.sv
// Time-multiplexes one external combinational Izhikevich integrator over
// N_NEURONS neurons: one sweep per step_start (FETCH current, EVAL, write
// back, SPIKE handshake on fire).
// Optional feature macro: NEURON_SCHED_REFRACT_EN adds per-neuron refractory
// counters; a refractory neuron costs a single skip cycle instead of FETCH+EVAL.
module neuron_scheduler
    import neuron_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int N_NEURONS = 8,
    parameter int IDX_W     = 3
`ifdef NEURON_SCHED_REFRACT_EN
    ,
    parameter int REFRACT_STEPS = REFRACT_STEPS_DEF
`endif
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    step_start,
    input  logic                    init_req,
    output logic                    busy,
    output logic                    step_done,
    output logic                    i_rd,
    output logic [IDX_W-1:0]        i_addr,
    input  logic [WIDTH-1:0]        i_data,
    output logic [WIDTH-1:0]        integ_I,
    output logic signed [WIDTH-1:0] integ_v_old,
    output logic signed [WIDTH-1:0] integ_w_old,
    input  logic signed [WIDTH-1:0] integ_v_new,
    input  logic signed [WIDTH-1:0] integ_w_new,
    input  logic                    integ_fire,
    output logic                    spike_valid,
    output logic [IDX_W-1:0]        spike_idx,
    input  logic                    spike_ready
);

    sched_state_t            state;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        nxt_idx;
    logic                    last;
    logic                    adv;
    logic                    skip;
    logic                    first_rd;
    logic                    nxt_rd;
    logic                    ram_we;
    logic                    ram_init;
    logic signed [WIDTH-1:0] rd_v;
    logic signed [WIDTH-1:0] rd_w;

    assign last     = (idx == IDX_W'(N_NEURONS - 1));
    assign nxt_idx  = idx + 1'b1;
    assign ram_we   = (state == EVAL);
    assign ram_init = (state == IDLE) && init_req;

`ifdef NEURON_SCHED_REFRACT_EN
    localparam int CNT_W = $clog2(REFRACT_STEPS + 1);

    logic [CNT_W-1:0] rcnt [N_NEURONS];

    // A refractory neuron is passed over at FETCH; the read strobe for the
    // upcoming neuron is suppressed up front because i_rd is registered.
    assign skip     = (state == FETCH) && (rcnt[idx] != '0);
    assign first_rd = (rcnt[0] == '0);
    assign nxt_rd   = (rcnt[nxt_idx] == '0);

    // Refractory counters: load on fire, count down once per skipped sweep
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_NEURONS; i++) rcnt[i] <= '0;
        end else if (ram_init) begin
            for (int i = 0; i < N_NEURONS; i++) rcnt[i] <= '0;
        end else if (state == EVAL && integ_fire) begin
            rcnt[idx] <= CNT_W'(REFRACT_STEPS);
        end else if (skip) begin
            rcnt[idx] <= rcnt[idx] - 1'b1;
        end
    end
`else
    assign skip     = 1'b0;
    assign first_rd = 1'b1;
    assign nxt_rd   = 1'b1;
`endif

    // Move on to the next neuron (or finish) after a clean EVAL, an accepted
    // spike, or a refractory skip.
    assign adv = skip
              || ((state == EVAL) && !integ_fire)
              || ((state == SPIKE) && spike_ready);

    neuron_state_ram #(
        .WIDTH     (WIDTH),
        .N_NEURONS (N_NEURONS),
        .IDX_W     (IDX_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .init    (ram_init),
        .raddr   (idx),
        .rdata_v (rd_v),
        .rdata_w (rd_w),
        .we      (ram_we),
        .waddr   (idx),
        .wdata_v (integ_v_new),
        .wdata_w (integ_w_new)
    );

    // Integrator sees zeros except while a neuron is actually being evaluated
    assign integ_I     = (state == EVAL) ? i_data : '0;
    assign integ_v_old = (state == EVAL) ? rd_v   : '0;
    assign integ_w_old = (state == EVAL) ? rd_w   : '0;

    // Sweep sequencer with registered handshake/status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            busy        <= 1'b0;
            step_done   <= 1'b0;
            i_rd        <= 1'b0;
            i_addr      <= '0;
            spike_valid <= 1'b0;
            spike_idx   <= '0;
        end else begin
            step_done <= 1'b0;
            i_rd      <= 1'b0;
            case (state)
                IDLE: begin
                    // init_req wins; the RAM handles it in this same cycle
                    if (!init_req && step_start) begin
                        state  <= FETCH;
                        idx    <= '0;
                        busy   <= 1'b1;
                        i_rd   <= first_rd;
                        i_addr <= '0;
                    end
                end
                FETCH: begin
                    if (!skip) state <= EVAL;
                end
                EVAL: begin
                    if (integ_fire) begin
                        state       <= SPIKE;
                        spike_valid <= 1'b1;
                        spike_idx   <= idx;
                    end
                end
                SPIKE: begin
                    if (spike_ready) spike_valid <= 1'b0;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            if (adv) begin
                if (last) begin
                    state     <= DONE;
                    step_done <= 1'b1;
                    busy      <= 1'b0;
                end else begin
                    state  <= FETCH;
                    idx    <= nxt_idx;
                    i_addr <= nxt_idx;
                    i_rd   <= nxt_rd;
                end
            end
        end
    end

endmodule
